// File: rtl/lsu_proto_pkg.sv
// Shared protocol definitions for the UART load/store link.
// Used by both the memory responder and the LSU initiator so that the
// command flag bytes and the FSM state encoding cannot drift apart.
//   FLAG_LOAD / FLAG_STORE : first byte of a transaction
//   state_t                : responder FSM state encoding
//   op_t                   : operation latched from the flag byte
package lsu_proto_pkg;

    localparam logic [7:0] FLAG_LOAD  = 8'h01;
    localparam logic [7:0] FLAG_STORE = 8'h02;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        GET_ADDR  = 4'd1,
        GET_HIGH  = 4'd2,
        GET_LOW   = 4'd3,
        WRITE     = 4'd4,
        READ      = 4'd5,
        READ_WAIT = 4'd6,
        SEND_HIGH = 4'd7,
        SEND_LOW  = 4'd8
    } state_t;

    typedef enum logic {
        OP_LOAD  = 1'b0,
        OP_STORE = 1'b1
    } op_t;

    // True in the states that are waiting for the next received byte.
    function automatic logic is_rx_state(input state_t s);
        return (s == GET_ADDR) || (s == GET_HIGH) || (s == GET_LOW);
    endfunction

endpackage

// File: rtl/byte_timer.sv
// Inter-byte idle timer.
// Counts enabled cycles since the last clear and flags expiry once the
// count reaches TIMEOUT_CYCLES. The count holds at that value until cleared.
//   clk, reset : clock, synchronous active-low reset
//   clr        : restart counting from zero (takes priority over en)
//   en         : count this cycle
//   expired    : count has reached TIMEOUT_CYCLES
module byte_timer #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd20000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [15:0] count;

    assign expired = (count == TIMEOUT_CYCLES);

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= 16'd0;
        end else if (clr) begin
            count <= 16'd0;
        end else if (en && !expired) begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/uart_mem_responder.sv
// UART-driven memory responder.
// Decodes byte transactions arriving from a UART receiver:
//   LOAD : 01, addr          -> one-cycle mem_re, reply with data high then low byte
//   STORE: 02, addr, hi, lo  -> one-cycle mem_we, no reply
// Unknown flag bytes and inter-byte silence of TIMEOUT_CYCLES pulse err.
// All outputs are registered: the next-state logic also computes the next
// output values, which are clocked together with the state.
//   clk, reset          : clock, synchronous active-low reset
//   rx_do, rx_data      : received byte strobe and value
//   tx_done             : transmitter finished current byte
//   tx_start_out        : active-low transmit request, tx_data_out the byte
//   mem_addr, mem_wdata : memory address / write data
//   mem_we, mem_re      : one-cycle write / read strobes
//   mem_rdata           : read data, valid the cycle after mem_re
//   busy                : not in IDLE
//   err                 : one-cycle error pulse
module uart_mem_responder
    import lsu_proto_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd20000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_do,
    input  logic [7:0]  rx_data,
    input  logic        tx_done,
    output logic        tx_start_out,
    output logic [7:0]  tx_data_out,
    output logic [7:0]  mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [15:0] mem_rdata,
    output logic        busy,
    output logic        err
);

    state_t      state, state_n;
    op_t         op, op_n;
    logic [15:0] hold, hold_n;
    logic [7:0]  mem_addr_n;
    logic [15:0] mem_wdata_n;
    logic        err_n;
    logic        tx_gap;
    logic        tx_start_n;
    logic [7:0]  tx_data_n;
    logic        timer_expired;

    // Timer runs only while waiting for a byte; any received byte and any
    // cycle outside the byte-wait states hold it at zero, so it is fresh on
    // entry to each wait state.
    byte_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clr    (rx_do || !is_rx_state(state)),
        .en     (is_rx_state(state)),
        .expired(timer_expired)
    );

    always_comb begin
        state_n     = state;
        op_n        = op;
        hold_n      = hold;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        err_n       = 1'b0;
        tx_gap      = 1'b0;

        case (state)
            IDLE: begin
                if (rx_do) begin
                    if (rx_data == FLAG_LOAD) begin
                        op_n    = OP_LOAD;
                        state_n = GET_ADDR;
                    end else if (rx_data == FLAG_STORE) begin
                        op_n    = OP_STORE;
                        state_n = GET_ADDR;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            GET_ADDR: begin
                if (rx_do) begin
                    mem_addr_n = rx_data;
                    state_n    = (op == OP_LOAD) ? READ : GET_HIGH;
                end else if (timer_expired) begin
                    state_n = IDLE;
                    err_n   = 1'b1;
                end
            end
            GET_HIGH: begin
                if (rx_do) begin
                    mem_wdata_n[15:8] = rx_data;
                    state_n           = GET_LOW;
                end else if (timer_expired) begin
                    state_n = IDLE;
                    err_n   = 1'b1;
                end
            end
            GET_LOW: begin
                if (rx_do) begin
                    mem_wdata_n[7:0] = rx_data;
                    state_n          = WRITE;
                end else if (timer_expired) begin
                    state_n = IDLE;
                    err_n   = 1'b1;
                end
            end
            WRITE:     state_n = IDLE;
            READ:      state_n = READ_WAIT;
            READ_WAIT: begin
                hold_n  = mem_rdata;
                state_n = SEND_HIGH;
            end
            // tx_done only counts while our request is actually asserted, so
            // a done arriving in the gap cycle at the start of SEND_LOW is not
            // mistaken for completion of the low byte.
            SEND_HIGH: begin
                if (tx_done && !tx_start_out) begin
                    state_n = SEND_LOW;
                    tx_gap  = 1'b1;
                end
            end
            SEND_LOW: begin
                if (tx_done && !tx_start_out) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        // Request is released for one cycle between the two reply bytes.
        tx_start_n = !(((state_n == SEND_HIGH) || (state_n == SEND_LOW)) && !tx_gap);
        tx_data_n  = 8'h00;
        if (state_n == SEND_HIGH) begin
            tx_data_n = hold_n[15:8];
        end else if (state_n == SEND_LOW) begin
            tx_data_n = hold_n[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            op           <= OP_LOAD;
            hold         <= 16'h0000;
            mem_addr     <= 8'h00;
            mem_wdata    <= 16'h0000;
            mem_we       <= 1'b0;
            mem_re       <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
            tx_start_out <= 1'b1;
            tx_data_out  <= 8'h00;
        end else begin
            state        <= state_n;
            op           <= op_n;
            hold         <= hold_n;
            mem_addr     <= mem_addr_n;
            mem_wdata    <= mem_wdata_n;
            mem_we       <= (state_n == WRITE);
            mem_re       <= (state_n == READ);
            busy         <= (state_n != IDLE);
            err          <= err_n;
            tx_start_out <= tx_start_n;
            tx_data_out  <= tx_data_n;
        end
    end

endmodule

// File: tb/tb_uart_mem_responder.sv
module tb_uart_mem_responder;

    localparam logic [15:0] TMO = 16'd20;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rx_do = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        tx_done = 1'b0;
    logic        tx_start_out;
    logic [7:0]  tx_data_out;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [15:0] mem_rdata = 16'h0000;
    logic        busy;
    logic        err;

    logic [15:0] rd_value = 16'h0000;

    int errors = 0;
    int checks = 0;

    // monitor state (written only by the monitor process)
    int          we_cnt = 0;
    int          re_cnt = 0;
    int          err_cnt = 0;
    int          txlow_cnt = 0;
    int          both_cnt = 0;
    logic [7:0]  we_addr = 8'h00;
    logic [15:0] we_wdata = 16'h0000;
    logic [7:0]  re_addr = 8'h00;

    uart_mem_responder #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_do       (rx_do),
        .rx_data     (rx_data),
        .tx_done     (tx_done),
        .tx_start_out(tx_start_out),
        .tx_data_out (tx_data_out),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .mem_re      (mem_re),
        .mem_rdata   (mem_rdata),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk = ~clk;

    // memory model: data valid exactly the cycle after mem_re, zero otherwise
    always @(posedge clk) begin
        mem_rdata <= mem_re ? rd_value : 16'h0000;
    end

    always @(negedge clk) begin
        if (reset) begin
            if (mem_we) begin
                we_cnt   <= we_cnt + 1;
                we_addr  <= mem_addr;
                we_wdata <= mem_wdata;
            end
            if (mem_re) begin
                re_cnt  <= re_cnt + 1;
                re_addr <= mem_addr;
            end
            if (err)           err_cnt   <= err_cnt + 1;
            if (!tx_start_out) txlow_cnt <= txlow_cnt + 1;
            if (mem_we && mem_re) both_cnt <= both_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_do   = 1'b1;
        @(negedge clk);
        rx_do   = 1'b0;
    endtask

    // Act as the UART transmitter for one byte; returns the byte sent.
    task automatic serve_tx(input string tag, output logic [7:0] b);
        int n;
        n = 0;
        while (tx_start_out && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_req"}, tx_start_out, 1'b0);
        b = tx_data_out;
        repeat (3) @(negedge clk);
        check({tag, "_stable"}, tx_data_out, b);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check({tag, "_release"}, tx_start_out, 1'b1);
    endtask

    initial begin
        logic [7:0] b;
        int we0, re0, err0, tl0, n;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_tx_start", tx_start_out, 1'b1);
        check("rst_tx_data", tx_data_out, 8'h00);
        check("rst_addr", mem_addr, 8'h00);
        check("rst_wdata", mem_wdata, 16'h0000);
        check("rst_we", mem_we, 1'b0);
        check("rst_re", mem_re, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err, 1'b0);
        reset = 1'b1;
        @(negedge clk);

        // load 3C -> BEEF
        rd_value = 16'hBEEF;
        re0 = re_cnt; err0 = err_cnt;
        send_byte(8'h01);
        send_byte(8'h3C);
        serve_tx("ld1_hi", b);
        check("ld1_hi_byte", b, 8'hBE);
        check("ld1_busy_mid", busy, 1'b1);
        serve_tx("ld1_lo", b);
        check("ld1_lo_byte", b, 8'hEF);
        check("ld1_busy_end", busy, 1'b0);
        check("ld1_re_cnt", re_cnt - re0, 1);
        check("ld1_re_addr", re_addr, 8'h3C);
        check("ld1_no_err", err_cnt - err0, 0);

        // store FF <- 1234
        we0 = we_cnt; re0 = re_cnt; tl0 = txlow_cnt;
        send_byte(8'h02);
        send_byte(8'hFF);
        send_byte(8'h12);
        send_byte(8'h34);
        repeat (4) @(negedge clk);
        check("st_we_cnt", we_cnt - we0, 1);
        check("st_we_addr", we_addr, 8'hFF);
        check("st_we_data", we_wdata, 16'h1234);
        check("st_no_tx", txlow_cnt - tl0, 0);
        check("st_no_re", re_cnt - re0, 0);
        check("st_busy", busy, 1'b0);

        // bad flag then normal load
        send_byte(8'h07);
        check("bad_err", err, 1'b1);
        check("bad_busy", busy, 1'b0);
        @(negedge clk);
        check("bad_err_pulse", err, 1'b0);
        rd_value = 16'h1357;
        send_byte(8'h01);
        send_byte(8'h10);
        serve_tx("ld2_hi", b);
        check("ld2_hi_byte", b, 8'h13);
        serve_tx("ld2_lo", b);
        check("ld2_lo_byte", b, 8'h57);
        check("ld2_re_addr", re_addr, 8'h10);

        // timeout in GET_LOW
        we0 = we_cnt; err0 = err_cnt;
        send_byte(8'h02);
        send_byte(8'h20);
        send_byte(8'hAA);
        n = 0;
        while (!err && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("tmo_latency", n, TMO + 1);
        check("tmo_err", err, 1'b1);
        check("tmo_busy", busy, 1'b0);
        @(negedge clk);
        check("tmo_err_pulse", err, 1'b0);
        check("tmo_err_cnt", err_cnt - err0, 1);
        check("tmo_no_we", we_cnt - we0, 0);

        // reset during SEND_HIGH
        rd_value = 16'hCAFE;
        send_byte(8'h01);
        send_byte(8'h05);
        n = 0;
        while (tx_start_out && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rs_in_send", tx_start_out, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check("rs_tx_start", tx_start_out, 1'b1);
        check("rs_busy", busy, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        rd_value = 16'h0102;
        send_byte(8'h01);
        send_byte(8'h05);
        serve_tx("ld3_hi", b);
        check("ld3_hi_byte", b, 8'h01);
        serve_tx("ld3_lo", b);
        check("ld3_lo_byte", b, 8'h02);

        // stray byte during SEND_LOW
        rd_value = 16'hA55A;
        err0 = err_cnt; we0 = we_cnt;
        send_byte(8'h01);
        send_byte(8'h40);
        serve_tx("ld4_hi", b);
        check("ld4_hi_byte", b, 8'hA5);
        send_byte(8'h02);
        serve_tx("ld4_lo", b);
        check("ld4_lo_byte", b, 8'h5A);
        check("ld4_busy_end", busy, 1'b0);
        rd_value = 16'h0F0F;
        send_byte(8'h01);
        send_byte(8'h41);
        serve_tx("ld5_hi", b);
        check("ld5_hi_byte", b, 8'h0F);
        serve_tx("ld5_lo", b);
        check("ld5_lo_byte", b, 8'h0F);
        check("ld5_re_addr", re_addr, 8'h41);
        check("stray_no_err", err_cnt - err0, 0);
        check("stray_no_we", we_cnt - we0, 0);

        check("we_re_exclusive", both_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_mem_responder.md
UART_MEM_RESPONDER -- requirements
Module: uart_mem_responder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16'd20000: max idle cycles between received bytes of one transaction.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port rx_do  input  1  one-cycle pulse, rx_data valid.
REQ-005 SHALL have port rx_data  input  8  received UART byte.
REQ-006 SHALL have port tx_done  input  1  one-cycle pulse, UART byte transmission finished.
REQ-007 SHALL have port tx_start_out  output  1  active-low transmit request, held low until tx_done.
REQ-008 SHALL have port tx_data_out  output  8  byte to transmit, stable while tx_start_out low.
REQ-009 SHALL have port mem_addr  output  8  memory word address.
REQ-010 SHALL have port mem_wdata  output  16  memory write data.
REQ-011 SHALL have port mem_we  output  1  one-cycle write strobe.
REQ-012 SHALL have port mem_re  output  1  one-cycle read strobe.
REQ-013 SHALL have port mem_rdata  input  16  read data, valid exactly one cycle after mem_re.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.
REQ-015 SHALL have port err  output  1  one-cycle pulse on bad flag or timeout.

Function
REQ-016 SHALL implement FSM states IDLE, GET_ADDR, GET_HIGH, GET_LOW, WRITE, READ, READ_WAIT, SEND_HIGH, SEND_LOW; all outputs registered.
REQ-017 IDLE: on rx_do with rx_data=8'h01 (LOAD) -> GET_ADDR, op=LOAD; 8'h02 (STORE) -> GET_ADDR, op=STORE; any other value -> stay IDLE, pulse err next cycle.
REQ-018 GET_ADDR: on rx_do latch rx_data into mem_addr; LOAD -> READ, STORE -> GET_HIGH.
REQ-019 GET_HIGH: on rx_do latch rx_data into mem_wdata[15:8] -> GET_LOW; GET_LOW: on rx_do latch mem_wdata[7:0] -> WRITE.
REQ-020 WRITE: mem_we high for exactly one cycle with stable mem_addr/mem_wdata -> IDLE; no UART acknowledge byte.
REQ-021 READ: mem_re high one cycle -> READ_WAIT; READ_WAIT: capture mem_rdata into 16-bit holding register -> SEND_HIGH.
REQ-022 SEND_HIGH: tx_start_out=0, tx_data_out=hold[15:8] until tx_done -> SEND_LOW; SEND_LOW: hold[7:0] until tx_done -> IDLE.
REQ-023 tx_start_out SHALL return to 1 in the cycle after tx_done and SHALL be 1 for at least one cycle between SEND_HIGH and SEND_LOW.
REQ-024 Outside SEND states tx_start_out=1 and tx_data_out=8'h00; tx_done ignored.
REQ-025 rx_do in READ, READ_WAIT, WRITE, SEND_HIGH, SEND_LOW SHALL be ignored (byte dropped, no err).
REQ-026 16-bit timeout counter SHALL clear on entry to GET_ADDR/GET_HIGH/GET_LOW and on every rx_do; reaching TIMEOUT_CYCLES -> IDLE, pulse err, no memory strobe.
REQ-027 Address 8'hFF and data 16'hFFFF SHALL be handled as ordinary values (no wrap or special case).
REQ-028 mem_we and mem_re SHALL never be high simultaneously.

Reset
REQ-029 reset=0 at a clock edge SHALL force IDLE from any state, aborting any transaction without memory strobe.
REQ-030 Reset values: tx_start_out=1, tx_data_out=0, mem_addr=0, mem_wdata=0, mem_we=0, mem_re=0, busy=0, err=0, timer=0, hold=0.

Structure
REQ-031 Flag constants FLAG_LOAD=8'h01, FLAG_STORE=8'h02 and the FSM state encoding SHALL live in shared package lsu_proto_pkg, also used by the LSU initiator.
REQ-032 Timeout counter SHALL be sub-module byte_timer (inputs clr, en; output expired).

Verification
REQ-033 Bytes 01,3C; mem_rdata=16'hBEEF after mem_re -> mem_re pulse with mem_addr=8'h3C, tx bytes BE then EF, busy falls after second tx_done.
REQ-034 Bytes 02,FF,12,34 -> single mem_we pulse, mem_addr=8'hFF, mem_wdata=16'h1234, no tx_start_out low.
REQ-035 Byte 07 in IDLE -> err one cycle, busy stays 0; following 01,10 completes a normal load.
REQ-036 Bytes 02,20,AA then silence TIMEOUT_CYCLES -> err pulse, IDLE, mem_we never asserted.
REQ-037 reset=0 during SEND_HIGH -> next cycle tx_start_out=1, busy=0; later 01,05 load succeeds.
REQ-038 Stray rx_do during SEND_LOW -> ignored; next transaction decodes from the next byte as a flag.
